// File: rtl/pc_gen_pkg.sv
// Shared CPU package for the fetch PC generator: vector defaults, FSM state
// encoding and the redirect-select enum.
package pc_gen_pkg;

  localparam logic [31:0] RESET_VECTOR_DEF = 32'h0000_3000;
  localparam logic [31:0] EXC_VECTOR_DEF   = 32'h0000_4180;
  localparam logic [31:0] PC_STEP          = 32'd4;

  typedef enum logic {
    RUN  = 1'b0,
    HOLD = 1'b1
  } pc_state_e;

  typedef enum logic [2:0] {
    SEL_NONE = 3'd0,
    SEL_BR   = 3'd1,
    SEL_J    = 3'd2,
    SEL_JR   = 3'd3,
    SEL_ERET = 3'd4,
    SEL_EXC  = 3'd5
  } redir_sel_e;

endpackage

// File: rtl/pc_gen_target_calc.sv
// Combinational redirect target computation and priority select.
// Exception/ERET participate only when PC_GEN_EXC_EN is defined.
module pc_target_calc
  import pc_gen_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEF
) (
  input  logic [31:0] id_pc_i,
  input  logic        br_taken_i,
  input  logic [15:0] br_off_i,
  input  logic        j_valid_i,
  input  logic [25:0] j_index_i,
  input  logic        jr_valid_i,
  input  logic [31:0] jr_target_i,
  input  logic        exc_i,
  input  logic        eret_i,
  input  logic [31:0] epc_i,
  output logic [31:0] target_o,
  output logic        redir_o,
  output logic        force_o
);

  redir_sel_e  sel;
  logic [31:0] seq_pc;
  logic [31:0] br_target;
  logic [31:0] j_target;

  assign seq_pc    = id_pc_i + PC_STEP;
  assign br_target = seq_pc + {{14{br_off_i[15]}}, br_off_i, 2'b00};
  assign j_target  = {seq_pc[31:28], j_index_i, 2'b00};

  // Later assignments override earlier ones, so the last line has top priority.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    sel = SEL_NONE;
    if (br_taken_i) sel = SEL_BR;
    if (j_valid_i)  sel = SEL_J;
    if (jr_valid_i) sel = SEL_JR;
`ifdef PC_GEN_EXC_EN
    if (eret_i)     sel = SEL_ERET;
    if (exc_i)      sel = SEL_EXC;
`endif
  end

  always_comb begin
    target_o = seq_pc;
    case (sel)
      SEL_BR:   target_o = br_target;
      SEL_J:    target_o = j_target;
      SEL_JR:   target_o = jr_target_i;
`ifdef PC_GEN_EXC_EN
      SEL_ERET: target_o = epc_i;
      SEL_EXC:  target_o = EXC_VECTOR;
`endif
      default:  target_o = seq_pc;
    endcase
  end

  assign redir_o = (sel == SEL_BR) || (sel == SEL_J) || (sel == SEL_JR);
  assign force_o = (sel == SEL_EXC) || (sel == SEL_ERET);

`ifndef PC_GEN_EXC_EN
  logic unused_exc;
  assign unused_exc = ^{exc_i, eret_i, epc_i, EXC_VECTOR};
`endif

endmodule

// File: rtl/pc_gen.sv
// Fetch PC generator with delay-slot redirects and stall capture (RUN/HOLD).
// Define PC_GEN_EXC_EN to enable the exc_i/eret_i override path.
module pc_gen
  import pc_gen_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEF,
  parameter logic [31:0] EXC_VECTOR   = EXC_VECTOR_DEF,
  parameter int          ADDR_W       = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall_i,
  input  logic [31:0] id_pc_i,
  input  logic        br_taken_i,
  input  logic [15:0] br_off_i,
  input  logic        j_valid_i,
  input  logic [25:0] j_index_i,
  input  logic        jr_valid_i,
  input  logic [31:0] jr_target_i,
  input  logic        exc_i,
  input  logic        eret_i,
  input  logic [31:0] epc_i,
  output logic [31:0] pc_o,
  output logic [31:0] link_o,
  output logic        adel_o,
  output logic        pend_o
);

  // The J-format concat only makes sense for a 32-bit PC.
  if (ADDR_W != 32) begin : g_bad_addr_w
    $error("pc_gen: ADDR_W must be 32");
  end

  pc_state_e   state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pend_q, pend_d;
  logic        adel_q;
  logic [31:0] target;
  logic        redir;
  logic        force_redir;

  pc_target_calc #(
    .EXC_VECTOR (EXC_VECTOR)
  ) u_target (
    .id_pc_i     (id_pc_i),
    .br_taken_i  (br_taken_i),
    .br_off_i    (br_off_i),
    .j_valid_i   (j_valid_i),
    .j_index_i   (j_index_i),
    .jr_valid_i  (jr_valid_i),
    .jr_target_i (jr_target_i),
    .exc_i       (exc_i),
    .eret_i      (eret_i),
    .epc_i       (epc_i),
    .target_o    (target),
    .redir_o     (redir),
    .force_o     (force_redir)
  );

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    pend_d  = pend_q;
    if (force_redir) begin
      pc_d    = target;
      pend_d  = '0;
      state_d = RUN;
    end else if (state_q == HOLD) begin
      // First captured redirect wins; new jr/j/br are ignored until release.
      if (!stall_i) begin
        pc_d    = pend_q;
        pend_d  = '0;
        state_d = RUN;
      end
    end else if (stall_i) begin
      if (redir) begin
        pend_d  = target;
        state_d = HOLD;
      end
    end else begin
      pc_d = redir ? target : pc_q + PC_STEP;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      pc_q    <= RESET_VECTOR;
      pend_q  <= '0;
      adel_q  <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments only.
      state_q <= state_d;
      pc_q    <= pc_d;
      pend_q  <= pend_d;
      adel_q  <= |pc_d[1:0];
    end
  end

  assign pc_o   = pc_q;
  assign adel_o = adel_q;
  assign pend_o = (state_q == HOLD);
  assign link_o = id_pc_i + 32'd8;

endmodule

// File: doc/pc_gen.md
PC_GEN -- requirements
Module: pc_gen

Interface
REQ-001 SHALL have parameter RESET_VECTOR, default 32'h0000_3000, meaning the first fetch address after reset.
REQ-002 SHALL have parameter EXC_VECTOR, default 32'h0000_4180, meaning the exception entry address.
REQ-003 SHALL have parameter ADDR_W, default 32, meaning the PC width; legal values are 32 only for the J-format concat, and other values SHALL fail elaboration.
REQ-004 SHALL have port clk, input, 1 bit: the single clock, with all state on its rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port stall_i, input, 1 bit: hold the fetch PC.
REQ-007 SHALL have port id_pc_i, input, 32 bits: PC of the control-transfer instruction in decode.
REQ-008 SHALL have port br_taken_i, input, 1 bit: a resolved conditional branch is taken.
REQ-009 SHALL have port br_off_i, input, 16 bits: branch immediate.
REQ-010 SHALL have port j_valid_i, input, 1 bit, with companion j_index_i, input, 26 bits: J/JAL target index.
REQ-011 SHALL have port jr_valid_i, input, 1 bit, with companion jr_target_i, input, 32 bits: JR/JALR target.
REQ-012 SHALL have port exc_i, input, 1 bit: take exception (EXC_EN only).
REQ-013 SHALL have port eret_i, input, 1 bit, with companion epc_i, input, 32 bits: return from exception (EXC_EN only).
REQ-014 SHALL have port pc_o, output, 32 bits: current fetch PC (registered).
REQ-015 SHALL have port link_o, output, 32 bits: id_pc_i + 8 (combinational).
REQ-016 SHALL have port adel_o, output, 1 bit: pc_o[1:0] != 0 (registered with pc_o).
REQ-017 SHALL have port pend_o, output, 1 bit: a redirect is latched awaiting stall release.

Function
REQ-018 SHALL compute targets as follows: branch = id_pc_i + 4 + (sext(br_off_i) << 2), mod 2^32; jump = {id_pc_i+4 [31:28], j_index_i, 2'b00}; jr = jr_target_i verbatim.
REQ-019 SHALL resolve redirect priority as exc_i > eret_i > jr_valid_i > j_valid_i > br_taken_i, so that at most one redirect wins per cycle.
REQ-020 SHALL update pc_o as follows when stall_i=0 and there is no pending redirect: pc_o <= winning target if any redirect is active, else pc_o + 4.
REQ-021 SHALL apply delay-slot semantics: the redirect is sampled while the delay slot is being fetched, so the instruction at id_pc_i+4 always executes and pc_o changes to the target on the next edge.
REQ-022 SHALL implement a two-state FSM, RUN and HOLD.
REQ-023 SHALL, in RUN with stall_i=1 and a non-exception redirect active, latch the target into pend_q, enter HOLD, and hold pc_o.
REQ-024 SHALL, in HOLD with stall_i=1, keep pc_o and pend_q unchanged and ignore further jr/j/br redirects (the first latched redirect wins).
REQ-025 SHALL, in HOLD with stall_i=0, set pc_o <= pend_q and return to RUN, ignoring the same-cycle jr/j/br.
REQ-026 SHALL let exc_i/eret_i override in any state, regardless of stall_i: pc_o <= EXC_VECTOR or epc_i, pend cleared, state RUN.
REQ-027 SHALL assert pend_o = 1 exactly while in HOLD.
REQ-028 SHALL wrap the sequential increment at 32'hFFFF_FFFC + 4 = 32'h0 with no flag.
REQ-029 SHALL NOT clear adel_o on its own; it tracks the registered pc_o, and downstream owns the exception.

Reset
REQ-030 SHALL, while rst_n=0, immediately drive pc_o=RESET_VECTOR, adel_o=0, pend_o=0, pend_q=0, state=RUN.
REQ-031 SHALL discard any pending redirect when reset is asserted mid-HOLD; the first edge after release yields pc_o=RESET_VECTOR+4 (if stall_i=0 and no redirect).

Configuration
REQ-032 SHALL, with macro PC_GEN_EXC_EN defined, implement exc_i/eret_i/epc_i as specified in REQ-026.
REQ-033 SHALL, without PC_GEN_EXC_EN, still present the exception ports but ignore them, set EXC_VECTOR unused, and reduce priority to jr > j > br.

Structure
REQ-034 SHALL place RESET_VECTOR/EXC_VECTOR defaults, the FSM state encoding (RUN=0, HOLD=1) and the redirect-select enum in the shared CPU package.
REQ-035 SHALL use one sub-module, pc_target_calc (combinational target/priority mux); the FSM and registers SHALL stay in pc_gen.

Verification
REQ-036 SHALL verify reset release: rst_n 0->1 with no redirect -> pc_o 3000, 3004, 3008 on successive edges.
REQ-037 SHALL verify a branch: id_pc_i=3004, br_taken_i=1, br_off_i=16'hFFFF -> next pc_o=3004; a second case with br_off_i=16'h0003 -> pc_o=3014.
REQ-038 SHALL verify a jump: id_pc_i=0040_3000, j_valid_i=1, j_index_i=26'h0000C40 -> pc_o=0000_3100.
REQ-039 SHALL verify stall capture: stall_i=1 with jr_valid_i=1, jr_target_i=3200 -> pc_o held and pend_o=1 for 3 cycles while a later j_valid_i is ignored; then stall_i=0 -> pc_o=3200 and pend_o=0.
REQ-040 SHALL verify exception override (EXC_EN): in HOLD, exc_i=1 -> pc_o=4180 and pend_o=0; then eret_i=1 with epc_i=3008 -> pc_o=3008.
REQ-041 SHALL verify misalignment: jr_target_i=3002 -> pc_o=3002 with adel_o=1; then mid-HOLD rst_n=0 -> pc_o=3000 and adel_o=0 immediately.
